// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller and its neighbours.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    DYING = 2'b10,
    OVER  = 2'b11
  } game_state_t;

  // Playfield geometry used by frog/cars/logs; lanes are one block tall.
  localparam int unsigned BLOCKSIZE = 32;
  localparam int unsigned LANE0_Y   = 13 * BLOCKSIZE;
  localparam int unsigned LANE1_Y   = 12 * BLOCKSIZE;
  localparam int unsigned LANE2_Y   = 11 * BLOCKSIZE;
  localparam int unsigned LANE3_Y   = 10 * BLOCKSIZE;
  localparam int unsigned LANE4_Y   =  9 * BLOCKSIZE;
  localparam int unsigned LANE5_Y   =  7 * BLOCKSIZE;
  localparam int unsigned LANE6_Y   =  6 * BLOCKSIZE;
  localparam int unsigned LANE7_Y   =  5 * BLOCKSIZE;
  localparam int unsigned LANE8_Y   =  4 * BLOCKSIZE;
  localparam int unsigned LANE9_Y   =  3 * BLOCKSIZE;

  localparam int unsigned DEF_LIVES_INIT   = 3;
  localparam int unsigned DEF_POINTS_CROSS = 10;

endpackage

// File: rtl/game_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a registered single-cycle edge pulse.
module sync_edge
  import game_pkg::*;
#(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;
  logic pulse_d;

  always_comb begin
    pulse_d = RISE ? (sync_q & ~prev_q) : (~sync_q & prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-flow FSM: IDLE/PLAY/DYING/OVER, lives, score, level and respawn pulse.
// Optional high-score register is enabled by defining GAME_CTRL_HISCORE_EN.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = DEF_LIVES_INIT,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned POINTS_CROSS = DEF_POINTS_CROSS,
  parameter int unsigned SCORE_W      = 10,
  parameter int unsigned MAX_LEVEL    = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               start_btn,
  input  logic               car_hit,
  input  logic               in_water,
  input  logic               reached_end,
  output logic [1:0]         state,
  output logic               round_rst,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level,
`ifdef GAME_CTRL_HISCORE_EN
  output logic [SCORE_W-1:0] hiscore,
`endif
  output logic               frame_tick
);

  localparam int unsigned TMR_W = ($clog2(DEATH_FRAMES) > 0) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEATH_FRAMES - 1);

  logic start_evt;
  logic frame_tick_w;

  sync_edge #(.RISE(1'b1)) u_start_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (start_btn),
    .pulse_o (start_evt)
  );

  sync_edge #(.RISE(1'b0)) u_vsync_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (vsync),
    .pulse_o (frame_tick_w)
  );

  game_state_t        state_q;
  logic               round_rst_q;
  logic [1:0]         lives_q;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         level_q;
  logic [TMR_W-1:0]   timer_q;
  logic               armed_q;
  logic               car_q;
  logic               water_q;
  logic               goal_q;
`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;
`endif

  logic               hazard;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [2:0]         level_inc;

  always_comb begin
    hazard    = car_q | water_q;
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS_CROSS);
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    level_inc = (level_q >= 3'(MAX_LEVEL)) ? level_q : level_q + 3'd1;
  end

  // armed_q is also cleared on every round_rst so that a goal can never
  // score on the cycle straight after a respawn; round_rst stays one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_rst_q <= 1'b0;
      lives_q     <= 2'(LIVES_INIT);
      score_q     <= '0;
      level_q     <= '0;
      timer_q     <= '0;
      armed_q     <= 1'b0;
      car_q       <= 1'b0;
      water_q     <= 1'b0;
      goal_q      <= 1'b0;
`ifdef GAME_CTRL_HISCORE_EN
      hiscore_q   <= '0;
`endif
    end else begin
      car_q       <= car_hit;
      water_q     <= in_water;
      goal_q      <= reached_end;
      round_rst_q <= 1'b0;
      if (!goal_q) armed_q <= 1'b1;

      case (state_q)
        IDLE, OVER: begin
          if (start_evt) begin
            state_q     <= PLAY;
            round_rst_q <= 1'b1;
            lives_q     <= 2'(LIVES_INIT);
            score_q     <= '0;
            level_q     <= '0;
            armed_q     <= 1'b0;
          end
        end
        PLAY: begin
          if (hazard) begin
            state_q <= DYING;
            timer_q <= '0;
          end else if (goal_q && armed_q) begin
            score_q     <= score_sat;
            level_q     <= level_inc;
            round_rst_q <= 1'b1;
            armed_q     <= 1'b0;
          end
        end
        DYING: begin
          if (frame_tick_w) begin
            if (timer_q == TMR_LAST) begin
              lives_q <= lives_q - 2'd1;
              if (lives_q == 2'd1) begin
                state_q <= OVER;
`ifdef GAME_CTRL_HISCORE_EN
                if (score_q > hiscore_q) hiscore_q <= score_q;
`endif
              end else begin
                state_q     <= PLAY;
                round_rst_q <= 1'b1;
                armed_q     <= 1'b0;
              end
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state      = state_q;
  assign round_rst  = round_rst_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign level      = level_q;
  assign frame_tick = frame_tick_w;
`ifdef GAME_CTRL_HISCORE_EN
  assign hiscore    = hiscore_q;
`endif

endmodule
